// File: rtl/input_keypad_pkg.sv
// Shared definitions for the keypad front end: controller key-command codes
// (the INPUT_INTERFACE code set) and the column-decoding helpers.
package input_keypad_pkg;

  localparam int IC_N  = 5;
  localparam int KEY_W = 5;

  localparam logic [IC_N-1:0] IC_NONE = 5'd0;
  localparam logic [IC_N-1:0] IC_0    = 5'd1;
  localparam logic [IC_N-1:0] IC_1    = 5'd2;
  localparam logic [IC_N-1:0] IC_2    = 5'd3;
  localparam logic [IC_N-1:0] IC_3    = 5'd4;
  localparam logic [IC_N-1:0] IC_4    = 5'd5;
  localparam logic [IC_N-1:0] IC_5    = 5'd6;
  localparam logic [IC_N-1:0] IC_6    = 5'd7;
  localparam logic [IC_N-1:0] IC_7    = 5'd8;
  localparam logic [IC_N-1:0] IC_8    = 5'd9;
  localparam logic [IC_N-1:0] IC_9    = 5'd10;
  localparam logic [IC_N-1:0] IC_AD   = 5'd11;
  localparam logic [IC_N-1:0] IC_SB   = 5'd12;
  localparam logic [IC_N-1:0] IC_MU   = 5'd13;
  localparam logic [IC_N-1:0] IC_DI   = 5'd14;
  localparam logic [IC_N-1:0] IC_LP   = 5'd15;
  localparam logic [IC_N-1:0] IC_RP   = 5'd16;
  localparam logic [IC_N-1:0] IC_OK   = 5'd17;
  localparam logic [IC_N-1:0] IC_CLBK = 5'd18;
  localparam logic [IC_N-1:0] IC_CLCL = 5'd19;

  // Columns are active-low: a zero bit means a closed switch in the driven row.
  function automatic logic [2:0] count_low(input logic [3:0] col);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!col[i]) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_keypad_map.sv
// Combinational key map: key index (row*4 + col) to controller command code.
module keypad_map
  import input_keypad_pkg::*;
(
  input  logic [KEY_W-1:0] key,
  output logic [IC_N-1:0]  code
);

  always_comb begin
    code = IC_NONE;
    case (key)
      5'd0:  code = IC_7;
      5'd1:  code = IC_8;
      5'd2:  code = IC_9;
      5'd3:  code = IC_DI;
      5'd4:  code = IC_4;
      5'd5:  code = IC_5;
      5'd6:  code = IC_6;
      5'd7:  code = IC_MU;
      5'd8:  code = IC_1;
      5'd9:  code = IC_2;
      5'd10: code = IC_3;
      5'd11: code = IC_SB;
      5'd12: code = IC_0;
      5'd13: code = IC_LP;
      5'd14: code = IC_RP;
      5'd15: code = IC_AD;
      5'd16: code = IC_CLBK;
      5'd17: code = IC_CLCL;
      5'd18: code = IC_OK;
      default: code = IC_NONE;
    endcase
  end

endmodule

// File: rtl/input_keypad.sv
// 5x4 matrix keypad scanner with frame-based debounce; issues one command per
// accepted press and holds it until the controller acknowledges.
module input_keypad
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_FRAMES = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [4:0]      kp_row,
  input  logic [3:0]      kp_col,
  output logic [IC_N-1:0] in_cmd,
  input  logic            in_ack
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_FRAMES);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [DIV_W-1:0] div;
  logic [2:0]       row_idx;
  logic [2:0]       row_next;
  logic [3:0]       col_s1, col_s2;
  logic             last_d1, last_d2;
  logic [2:0]       row_d1, row_d2;
  logic [1:0]       acc_cnt;
  logic [KEY_W-1:0] acc_key;
  logic [2:0]       row_lows;
  logic [2:0]       sum_raw;
  logic [1:0]       sum_cnt;
  logic [KEY_W-1:0] this_key;
  logic [KEY_W-1:0] frame_key;
  logic             frame_end;
  logic             frame_hit;
  logic [1:0]       state;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_next;
  logic             deb_done;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] map_in;
  logic [IC_N-1:0]  key_code;

  assign row_next = (row_idx == 3'd4) ? 3'd0 : row_idx + 3'd1;

  // Free-running row scan; never disturbed by the debounce FSM.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      div     <= '0;
      row_idx <= 3'd0;
      kp_row  <= 5'b11110;
    end else if (div == DIV_LAST) begin
      div     <= '0;
      row_idx <= row_next;
      kp_row  <= ~(5'b00001 << row_next);
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // The row tag travels alongside the column synchroniser so each sample is
  // attributed to the row that was driven in the last cycle of its slot.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      col_s1  <= 4'hF;
      col_s2  <= 4'hF;
      last_d1 <= 1'b0;
      last_d2 <= 1'b0;
      row_d1  <= 3'd0;
      row_d2  <= 3'd0;
    end else begin
      col_s1  <= kp_col;
      col_s2  <= col_s1;
      last_d1 <= (div == DIV_LAST);
      last_d2 <= last_d1;
      row_d1  <= row_idx;
      row_d2  <= row_d1;
    end
  end

  always_comb begin
    row_lows  = count_low(col_s2);
    this_key  = {row_d2, first_low(col_s2)};
    sum_raw   = {1'b0, acc_cnt} + row_lows;
    sum_cnt   = (sum_raw >= 3'd2) ? 2'd2 : sum_raw[1:0];
    frame_key = (acc_cnt != 2'd0) ? acc_key : this_key;
    frame_end = last_d2 && (row_d2 == 3'd4);
    frame_hit = frame_end && (sum_cnt == 2'd1);
  end

  // Count of closed switches per frame saturates at two: anything above one is "none".
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      acc_cnt <= 2'd0;
      acc_key <= '0;
    end else if (last_d2) begin
      acc_cnt <= frame_end ? 2'd0 : sum_cnt;
      if (acc_cnt == 2'd0) acc_key <= this_key;
    end
  end

  assign map_in   = (state == ST_SCAN) ? frame_key : key;
  assign deb_next = (state == ST_SCAN) ? DEB_W'(1) : deb_cnt + DEB_W'(1);
  assign deb_done = (deb_next >= DEB_LAST);

  keypad_map u_map (
    .key  (map_in),
    .code (key_code)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= ST_SCAN;
      in_cmd  <= IC_NONE;
      deb_cnt <= '0;
      key     <= '0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (frame_hit) begin
            key <= frame_key;
            if (deb_done) begin
              deb_cnt <= '0;
              if (key_code == IC_NONE) state <= ST_RELEASE;
              else begin
                state  <= ST_HOLD;
                in_cmd <= key_code;
              end
            end else begin
              deb_cnt <= deb_next;
              state   <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_end) begin
            if (frame_hit && (frame_key == key)) begin
              if (deb_done) begin
                deb_cnt <= '0;
                if (key_code == IC_NONE) state <= ST_RELEASE;
                else begin
                  state  <= ST_HOLD;
                  in_cmd <= key_code;
                end
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              state   <= ST_SCAN;
              deb_cnt <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (in_ack) begin
            in_cmd  <= IC_NONE;
            deb_cnt <= '0;
            state   <= ST_RELEASE;
          end
        end
        default: begin
          // Only an unbroken run of empty frames re-arms the scanner.
          if (frame_end) begin
            if (!frame_hit) begin
              if (deb_done) begin
                deb_cnt <= '0;
                state   <= ST_SCAN;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              deb_cnt <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_keypad.sv
// Bench for input_keypad: an ideal switch matrix driven frame by frame, with
// expected commands taken from a run-length model of the debounce rules.
module tb_input_keypad;
  import input_keypad_pkg::*;

  localparam int SCAN_DIV   = 2;
  localparam int DEB_FRAMES = 2;

  logic            clock;
  logic            reset;
  logic [4:0]      kp_row;
  logic [3:0]      kp_col;
  logic [IC_N-1:0] in_cmd;
  logic            in_ack;
  logic [19:0]     pressed;

  int n_cmp;
  int n_err;

  logic [IC_N-1:0] key_code [20];

  logic [IC_N-1:0] m_cmd;
  bit m_hold, m_armed, pend_valid;
  int m_run_key, m_run_len, m_quiet, pend_res;

  input_keypad #(.SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB_FRAMES)) dut (
    .Clock  (clock),
    .Reset  (reset),
    .kp_row (kp_row),
    .kp_col (kp_col),
    .in_cmd (in_cmd),
    .in_ack (in_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Ideal switch matrix: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp_row[r] && pressed[r*4+c]) kp_col[c] = 1'b0;
      end
    end
  end

  function automatic int frame_result(input logic [19:0] k);
    int idx;
    idx = -1;
    if ($countones(k) == 1) begin
      for (int i = 0; i < 20; i++) if (k[i]) idx = i;
    end
    return idx;
  endfunction

  task automatic model_reset();
    m_cmd = IC_NONE; m_hold = 0; m_armed = 1;
    m_run_key = -1; m_run_len = 0; m_quiet = 0; pend_valid = 0;
  endtask

  task automatic model_frame(input int r);
    if (m_hold) return;
    if (!m_armed) begin
      if (r < 0) begin
        m_quiet++;
        if (m_quiet >= DEB_FRAMES) begin m_armed = 1; m_run_len = 0; end
      end else m_quiet = 0;
      return;
    end
    if (r >= 0 && (m_run_len == 0 || r == m_run_key)) begin
      m_run_key = r; m_run_len++;
    end else m_run_len = 0;
    if (m_run_len >= DEB_FRAMES) begin
      m_run_len = 0;
      if (key_code[r] == IC_NONE) begin m_armed = 0; m_quiet = 0; end
      else begin m_hold = 1; m_cmd = key_code[r]; end
    end
  endtask

  task automatic model_ack();
    if (m_hold) begin m_hold = 0; m_cmd = IC_NONE; m_armed = 0; m_quiet = 0; end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One scan frame, entered and left on the negedge of the frame's first cycle.
  task automatic applyStimulus(input string tag, input logic [19:0] keys, input bit ack);
    pressed = keys;
    checkOutput({tag, "_row0"}, {3'b0, kp_row}, 8'h1E);
    checkOutput({tag, "_pre"}, {3'b0, in_cmd}, {3'b0, m_cmd});
    repeat (2) @(negedge clock);
    if (pend_valid) model_frame(pend_res);
    checkOutput({tag, "_cmd"}, {3'b0, in_cmd}, {3'b0, m_cmd});
    checkOutput({tag, "_row1"}, {3'b0, kp_row}, 8'h1D);
    repeat (3) @(negedge clock);
    if (ack) begin
      in_ack = 1'b1;
      @(negedge clock);
      in_ack = 1'b0;
      model_ack();
      checkOutput({tag, "_ack"}, {3'b0, in_cmd}, {3'b0, m_cmd});
      repeat (4) @(negedge clock);
    end else begin
      repeat (5) @(negedge clock);
    end
    pend_res   = frame_result(keys);
    pend_valid = 1;
  endtask

  task automatic frames(input string tag, input logic [19:0] keys, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, keys, 1'b0);
  endtask

  initial begin
    logic [19:0] k;
    int sel, len;
    key_code = '{IC_7, IC_8, IC_9, IC_DI, IC_4, IC_5, IC_6, IC_MU,
                 IC_1, IC_2, IC_3, IC_SB, IC_0, IC_LP, IC_RP, IC_AD,
                 IC_CLBK, IC_CLCL, IC_OK, IC_NONE};
    n_cmp = 0; n_err = 0;
    reset = 1'b1; in_ack = 1'b0; pressed = '0;
    model_reset();
    repeat (3) @(negedge clock);
    checkOutput("rst_cmd", {3'b0, in_cmd}, {3'b0, IC_NONE});
    checkOutput("rst_row", {3'b0, kp_row}, 8'h1E);
    reset = 1'b0;

    // Key "5" held: command after the second frame, stable without ack.
    frames("k5", 20'h00020, 4);
    checkOutput("k5_held", {3'b0, in_cmd}, {3'b0, IC_5});
    applyStimulus("k5_ack", 20'h00020, 1'b1);
    frames("k5_more", 20'h00020, 5);
    frames("k5_rel", 20'h00000, 2);
    // Two keys in the same row never register.
    frames("k78", 20'h00003, 4);
    frames("idle", 20'h00000, 1);
    // Single-frame bounce, then a genuine "=".
    frames("plus", 20'h08000, 1);
    frames("idle", 20'h00000, 1);
    frames("eq", 20'h40000, 2);
    applyStimulus("eq_ack", 20'h00000, 1'b1);
    frames("idle", 20'h00000, 2);
    // Spare key is swallowed; the following "0" still gets through.
    frames("spare", 20'h80000, 3);
    frames("idle", 20'h00000, 2);
    frames("k0", 20'h01000, 2);
    applyStimulus("k0_ack", 20'h00000, 1'b1);
    frames("idle", 20'h00000, 2);
    // Clear key reaches HOLD, then reset lands asynchronously mid-cycle.
    frames("clcl", 20'h20000, 2);
    repeat (2) @(negedge clock);
    if (pend_valid) model_frame(pend_res);
    checkOutput("clcl_hold", {3'b0, in_cmd}, {3'b0, m_cmd});
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_cmd", {3'b0, in_cmd}, {3'b0, IC_NONE});
    checkOutput("async_row", {3'b0, kp_row}, 8'h1E);
    pressed = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Randomised press patterns with stray acknowledges.
    for (int i = 0; i < 14; i++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 4);
      k = '0;
      if (sel >= 4 && sel <= 7) k[$urandom_range(0, 19)] = 1'b1;
      else if (sel >= 8) begin
        k[$urandom_range(0, 19)] = 1'b1;
        k[$urandom_range(0, 19)] = 1'b1;
      end
      for (int j = 0; j < len; j++) applyStimulus("rnd", k, ($urandom_range(0, 3) == 0));
    end
    applyStimulus("rnd_end", 20'h00000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_keypad.md
INPUT_KEYPAD -- requirements
Module: input_keypad

Interface
REQ-001 The block SHALL take parameter SCAN_DIV, default 1000: clock cycles each keypad row is driven.
REQ-002 The block SHALL take parameter DEB_FRAMES, default 4: consecutive identical scan frames needed to accept a press or a release.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port kp_row, output, 5 bits: row drive, one row low at a time, others high.
REQ-006 The block SHALL have port kp_col, input, 4 bits: column sense, active-low, externally pulled up; SHALL be double-flop synchronised before use.
REQ-007 The block SHALL have port in_cmd, output, `IC_N bits: key command to the controller; `IC_NONE when idle.
REQ-008 The block SHALL have port in_ack, input, 1 bit: controller consume strobe.

Function
REQ-009 The row scan SHALL step row 0..4 cyclically; each row is held for SCAN_DIV cycles; one frame = 5*SCAN_DIV cycles.
REQ-010 The synchronised kp_col SHALL be sampled on the last cycle of each row slot only.
REQ-011 At each frame end, the frame result SHALL be the key index (row*4+col) if exactly one key was low in the frame, else "none"; multi-key frames count as "none".
REQ-012 The key map SHALL be:
- row0: 7 8 9 /
- row1: 4 5 6 *
- row2: 1 2 3 -
- row3: 0 ( ) +
- row4: CLBK CLCL = spare
REQ-013 The spare key SHALL map to `IC_NONE and never be issued.
REQ-014 The codes SHALL be the `IC_* values from INPUT_INTERFACE.v:
- digits -> `IC_0..`IC_9
- operators -> `IC_AD `IC_SB `IC_MU `IC_DI `IC_LP `IC_RP `IC_OK
- backspace -> `IC_CLBK
- clear -> `IC_CLCL
REQ-015 The FSM SHALL have states SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-016 In SCAN, a valid single-key frame SHALL latch the key, set deb_cnt=1 and enter DEBOUNCE.
REQ-017 In DEBOUNCE, on each frame:
- same key: deb_cnt+1
- different key or "none": return to SCAN, deb_cnt=0
- deb_cnt reaching DEB_FRAMES: enter HOLD
REQ-018 On entering HOLD, in_cmd SHALL become the mapped code on the clock edge following the frame end of the DEB_FRAMES-th matching frame.
REQ-019 In HOLD, in_cmd SHALL stay stable until in_ack=1 is sampled on a rising edge; that edge SHALL set in_cmd=`IC_NONE and enter RELEASE.
REQ-020 In HOLD, scanning SHALL continue but frame results SHALL be ignored: no second command and no overwrite.
REQ-021 In RELEASE, DEB_FRAMES consecutive "none" frames SHALL return the FSM to SCAN; any key frame SHALL restart the count, so auto-repeat is impossible.
REQ-022 in_ack outside HOLD SHALL be ignored.
REQ-023 A key whose map is `IC_NONE SHALL go directly to RELEASE instead of HOLD.
REQ-024 The row and frame counters SHALL wrap freely and SHALL NOT be reset by FSM transitions.

Reset
REQ-025 While Reset=1, regardless of any operation in progress:
- state=SCAN, in_cmd=`IC_NONE
- kp_row=5'b11110, row index 0, divider 0
- deb_cnt 0, synchronisers all ones
REQ-026 Scanning SHALL restart at row 0 on the first edge after Reset falls.

Structure
REQ-027 The `IC_* codes and `IC_N SHALL come from INPUT_INTERFACE.v; state encodings SHALL be local constants.
REQ-028 The key map SHALL be the combinational sub-module keypad_map (5-bit index in, `IC_N code out).

Verification (SCAN_DIV=2, DEB_FRAMES=2, frame = 10 cycles)
REQ-029 Hold key "5" (row1, col1) for 4 frames, in_ack=0 -> in_cmd=`IC_5 one cycle after the 2nd frame end, held indefinitely.
REQ-030 In the REQ-029 condition, pulse in_ack for 1 cycle -> in_cmd=`IC_NONE the next cycle; hold the key 5 more frames, then release for 2 frames -> no second `IC_5.
REQ-031 Press "7" and "8" together for 4 frames -> in_cmd stays `IC_NONE.
REQ-032 Press "+" for 1 frame only (bounce) -> no command; then press "=" for 2 frames -> `IC_OK.
REQ-033 Assert Reset while in HOLD with `IC_CLCL -> in_cmd=`IC_NONE immediately (asynchronous), kp_row=5'b11110.
REQ-034 Press the spare key for 3 frames, then release for 2 frames, then press "0" for 2 frames -> only `IC_0 is issued.
